stream_mux_n_to_1: RTL

STREAM_MUX_N_TO_1 -- requirements
Module: stream_mux_n_to_1

---
 rtl/stream_mux_n_to_1.sv | 68 ++++++
 1 files changed

// File: rtl/stream_mux_n_to_1.sv
// stream_mux_n_to_1: N-to-1 valid/ready stream mux with select/priority/round-robin arbitration and a registered output stage
module stream_mux_n_to_1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_chan,
  input  logic             out_ready
);
  logic          can_load;
  logic          gnt_ok;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] idx;
  logic [SW-1:0] ptr;
  logic          xfer;
  assign can_load = !out_valid || out_ready;
  assign in_ready = (reset_n && can_load && gnt_ok) ? N'(1) << gnt_idx : '0;
  assign xfer     = |in_ready;
  // arbitration: pick the granted channel for the current mode; descending loops let the lowest search offset win
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (mode == 2'b00) begin
      gnt_ok  = (32'(sel) < N) && in_valid[sel];
      gnt_idx = sel;
    end else if (mode == 2'b01) begin
      for (int k = N - 1; k >= 0; k--)
        if (in_valid[k]) begin
          gnt_ok  = 1'b1;
          gnt_idx = SW'(k);
        end
    end else if (mode == 2'b10) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = SW'((int'(ptr) + i) % N);
        if (in_valid[idx]) begin
          gnt_ok  = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end
  // output register and round-robin pointer; load-while-drain keeps one beat per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_chan  <= gnt_idx;
      if (mode == 2'b10) ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
